alu_nibble_serial: RTL
======================

# alu_nibble_serial

Parametrised, nibble-serial successor to the team's 4-bit 74181-style ALU.
- Executes the full 16-function logic/arithmetic set on WIDTH-bit operands by reusing one 4-bit slice for WIDTH/4 cycles, LSB nibble first.
- Carry is held in a register between nibbles.
- Operands enter, and results leave, through valid/ready handshakes.
- Used where a wide ALU is needed but area matters more than throughput.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4, otherwise elaboration error.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_valid_i  in  1  operation request.
- start_ready_o  out  1  block can accept a request.
- S_selection_i  in  4  function select.
- mode_control_i  in  1  1 = logic, 0 = arithmetic.
- carry_in_i  in  1  active-high carry in (+1).
- A_i, B_i  in  WIDTH  operands.
- result_valid_o  out  1  result outputs valid.
- result_ready_i  in  1  consumer takes result.
- F_o  out  WIDTH  result.
- carry_out_o  out  1  carry out of bit WIDTH-1.
- overflow_o  out  1  signed overflow.
- equality_o  out  1  &F_o (A=B when S=0110, M=0, Cn=0).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready_o = 1.
  - On start_valid_i & start_ready_o: latch A, B, S, M, Cn; carry register ← carry_in_i; nibble counter ← 0; go to RUN.
- RUN, each cycle:
  - Slice computes nibble k from A[4k+3:4k], B[4k+3:4k] and the carry register.
  - Write F[4k+3:4k]; carry register ← slice carry out; k++.
  - After nibble WIDTH/4-1, go to DONE.
- DONE:
  - result_valid_o = 1; F_o and flags held stable.
  - On result_ready_i, go to IDLE.
- Logic mode (M=1), bitwise results for S = 0000…1111:
  - ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B
  - ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A
  - carry_out_o = 0, overflow_o = 0.
- Arithmetic mode (M=0): F = P + Q + Cn, modulo 2^WIDTH. P,Q for S = 0000…1111:
  - A,0 · A|B,0 · A|~B,0 · 0,ones
  - A,A&~B · A|B,A&~B · A,~B · A&~B,ones
  - A,A&B · A,B · A|~B,A&B · A&B,ones
  - A,A · A|B,A · A|~B,A · A,ones
  - "ones" = all-ones (−1).
  - carry_out_o = bit WIDTH of the full sum.
  - overflow_o = carry into MSB XOR carry out of MSB.
- Inputs other than start_valid_i are ignored outside the accept cycle.

## Timing
- Reset values:
  - State IDLE; start_ready_o 1.
  - result_valid_o 0; F_o 0; carry_out_o 0; overflow_o 0; equality_o 0.
- Latency: request accepted at edge t → result_valid_o high after edge t+WIDTH/4.
- Throughput: one op per WIDTH/4+2 cycles with no backpressure. No accept in RUN or DONE.
- Output registers update only in RUN. They hold through DONE and IDLE until the next RUN overwrites them.
- Reset asserted mid-RUN or in DONE: operation is aborted, all outputs return to their reset values immediately, and no partial result is presented.
- result_ready_i high while not in DONE: ignored.

## Structure
- Shared package alu_pkg holds:
  - FSM state enum.
  - Localparams for S codes (e.g. S_ADD = 4'b1001, S_SUB = 4'b0110).
  - NIBBLE = 4.
- Sub-module alu_nibble: combinational 4-bit slice.
  - In: a[3:0], b[3:0], S, M, cin.
  - Out: f[3:0], cout, c3 (carry into bit 3, used for overflow on the last nibble).
- Top level holds: FSM, counter ($clog2(WIDTH/4) bits, min 1), operand/result registers, flags.

## Test plan
All scenarios use WIDTH=16.
- M=0, S=1001, Cn=0, A=0x1234, B=0x0FFF → F=0x2233, carry 0, overflow 0; result_valid_o high exactly 4 cycles after accept.
- M=0, S=0110, Cn=1, A=0x0005, B=0x0007 → F=0xFFFE, carry 0, overflow 0.
- M=0, S=0110, Cn=0, A=B=0xBEEF → F=0xFFFF, equality_o 1, carry 0.
- M=0, S=1001, Cn=1, A=0x7FFF, B=0x0000 → F=0x8000, overflow 1, carry 0.
- Backpressure: M=1, S=0110, A=0xF0F0, B=0xFF00 → F=0x0FF0. Hold result_ready_i low 5 cycles → F_o stable, start_ready_o 0, start_valid_i ignored; release → IDLE next edge.
- Assert rst_n_i 2 cycles into RUN → all outputs at reset values without waiting for an edge. After release, start_ready_o = 1 and the next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial ALU.
// One 4-bit slice is reused across the operand width.
package alu_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] S_ZERO = 4'b0011;
  localparam logic [3:0] S_SUB  = 4'b0110;
  localparam logic [3:0] S_AND  = 4'b1011;
  localparam logic [3:0] S_ADD  = 4'b1001;
  localparam logic [3:0] S_DBL  = 4'b1100;
  localparam logic [3:0] S_DEC  = 4'b1111;

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit 74181-style slice.
// c3 is the carry into bit 3, needed for overflow on the top nibble.
import alu_pkg::*;

module alu_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] q;
  logic [3:0] lf;
  logic [4:0] sum;
  logic [3:0] lo;

  always_comb begin
    p = '0;
    q = '0;
    unique case (s)
      4'b0000: begin p = a;      q = '0;     end
      4'b0001: begin p = a | b;  q = '0;     end
      4'b0010: begin p = a | ~b; q = '0;     end
      S_ZERO:  begin p = '0;     q = '1;     end
      4'b0100: begin p = a;      q = a & ~b; end
      4'b0101: begin p = a | b;  q = a & ~b; end
      S_SUB:   begin p = a;      q = ~b;     end
      4'b0111: begin p = a & ~b; q = '1;     end
      4'b1000: begin p = a;      q = a & b;  end
      S_ADD:   begin p = a;      q = b;      end
      4'b1010: begin p = a | ~b; q = a & b;  end
      S_AND:   begin p = a & b;  q = '1;     end
      S_DBL:   begin p = a;      q = a;      end
      4'b1101: begin p = a | b;  q = a;      end
      4'b1110: begin p = a | ~b; q = a;      end
      S_DEC:   begin p = a;      q = '1;     end
      default: begin p = '0;     q = '0;     end
    endcase
  end

  always_comb begin
    lf = '0;
    unique case (s)
      4'b0000: lf = ~a;
      4'b0001: lf = ~(a | b);
      4'b0010: lf = ~a & b;
      4'b0011: lf = '0;
      4'b0100: lf = ~(a & b);
      4'b0101: lf = ~b;
      4'b0110: lf = a ^ b;
      4'b0111: lf = a & ~b;
      4'b1000: lf = ~a | b;
      4'b1001: lf = ~(a ^ b);
      4'b1010: lf = b;
      4'b1011: lf = a & b;
      4'b1100: lf = '1;
      4'b1101: lf = a | ~b;
      4'b1110: lf = a | b;
      4'b1111: lf = a;
      default: lf = '0;
    endcase
  end

  assign sum = {1'b0, p} + {1'b0, q} + {4'b0, cin};
  assign lo  = {1'b0, p[2:0]} + {1'b0, q[2:0]} + {3'b0, cin};

  always_comb begin
    if (m) begin
      f    = lf;
      cout = 1'b0;
      c3   = 1'b0;
    end else begin
      f    = sum[3:0];
      cout = sum[4];
      c3   = lo[3];
    end
  end

endmodule

// File: rtl/alu_nibble_serial.sv
// WIDTH-bit ALU built from one 4-bit slice, LSB nibble first.
// Result registers change only while running and hold afterwards.
import alu_pkg::*;

module alu_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [3:0]       S_selection_i,
  input  logic             mode_control_i,
  input  logic             carry_in_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [WIDTH-1:0] F_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             equality_o
);

  localparam int NN = WIDTH / NIBBLE;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
    $error("alu_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    base;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [WIDTH-1:0] f_q;
  logic             co_q;
  logic             ov_q;
  logic             rdy_q;
  logic             vld_q;

  logic [3:0]       sl_f;
  logic             sl_cout;
  logic             sl_c3;

  assign base = IW'(cnt) << 2;

  alu_nibble u_slice (
    .a    (a_q[base +: NIBBLE]),
    .b    (b_q[base +: NIBBLE]),
    .s    (s_q),
    .m    (m_q),
    .cin  (carry_q),
    .f    (sl_f),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      f_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start_valid_i) begin
            a_q     <= A_i;
            b_q     <= B_i;
            s_q     <= S_selection_i;
            m_q     <= mode_control_i;
            carry_q <= carry_in_i;
            cnt     <= '0;
            rdy_q   <= 1'b0;
            state   <= RUN;
          end
        end
        (state == RUN): begin
          f_q[base +: NIBBLE] <= sl_f;
          carry_q <= sl_cout;
          co_q    <= sl_cout;
          // only the top nibble's value survives
          ov_q    <= sl_cout ^ sl_c3;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(NN - 1)) begin
            vld_q <= 1'b1;
            state <= DONE;
          end
        end
        (state == DONE): begin
          if (result_ready_i) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign start_ready_o  = rdy_q;
  assign result_valid_o = vld_q;
  assign F_o            = f_q;
  assign carry_out_o    = co_q;
  assign overflow_o     = ov_q;
  assign equality_o     = &f_q;

endmodule
